// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage RV32 branch resolver with 2-bit BHT and registered redirect
// Ports: clock_i/reset_i (sync, active-high); f_pc_i -> f_pred_tk_o (combinational BHT lookup);
//        e_* branch in EX; br_tk_o, redirect_valid_o, redirect_pc_o registered results.
// Optional: define BRANCH_STATS_EN to add stat_branches_o / stat_mispredicts_o (STAT_W, saturating).
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int STAT_W      = 32
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic [XLEN-1:0] f_pc_i,
  output logic            f_pred_tk_o,
  input  logic            e_valid_i,
  input  logic            e_stall_i,
  input  logic [2:0]      e_funct3_i,
  input  logic [XLEN-1:0] e_rs1_i,
  input  logic [XLEN-1:0] e_rs2_i,
  input  logic [XLEN-1:0] e_pc_i,
  input  logic [XLEN-1:0] e_target_i,
  input  logic            e_pred_tk_i,
  output logic            br_tk_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches_o,
  output logic [STAT_W-1:0] stat_mispredicts_o
`endif
);
  localparam int IDX_W = $clog2(BHT_ENTRIES);
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic             br_tk_q, br_tk_d, redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [IDX_W-1:0] e_idx;
  logic [1:0]       ctr, ctr_d;
  logic             eq, lts, ltu, tk, legal, resolve;
  logic             unused_f_pc;
  assign unused_f_pc = ^{f_pc_i[XLEN-1:IDX_W+2], f_pc_i[1:0]};
  assign f_pred_tk_o = bht_q[f_pc_i[IDX_W+1:2]][1];
  assign e_idx = e_pc_i[IDX_W+1:2];
  assign ctr   = bht_q[e_idx];
  assign eq    = e_rs1_i == e_rs2_i;
  assign lts   = $signed(e_rs1_i) < $signed(e_rs2_i);
  assign ltu   = e_rs1_i < e_rs2_i;
  // funct3[0] inverts the base compare: BNE/BGE/BGEU
  assign tk    = (e_funct3_i[2] ? (e_funct3_i[1] ? ltu : lts) : eq) ^ e_funct3_i[0];
  assign legal = e_funct3_i[2:1] != 2'b01;
  // a live redirect means EX holds a wrong-path instruction
  assign resolve = e_valid_i & ~e_stall_i & ~redirect_valid_q & legal;
  assign br_tk_d          = resolve ? tk : br_tk_q;
  assign redirect_valid_d = resolve & (tk != e_pred_tk_i);
  assign redirect_pc_d    = resolve ? (tk ? e_target_i : e_pc_i + XLEN'(4)) : redirect_pc_q;
  assign ctr_d = tk ? ctr + 2'(ctr != 2'b11) : ctr - 2'(ctr != 2'b00);
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      br_tk_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      br_tk_q          <= br_tk_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      if (resolve) bht_q[e_idx] <= ctr_d;
    end
  end
  assign br_tk_o          = br_tk_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] stat_branches_q, stat_mispredicts_q;
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (resolve) begin
      stat_branches_q    <= stat_branches_q + STAT_W'(stat_branches_q != '1);
      stat_mispredicts_q <= stat_mispredicts_q + STAT_W'(redirect_valid_d && stat_mispredicts_q != '1);
    end
  end
  assign stat_branches_o    = stat_branches_q;
  assign stat_mispredicts_o = stat_mispredicts_q;
`else
  localparam int unused_stat_w = STAT_W;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed bench with a behavioural model of branch_resolve_unit
module tb_branch_resolve_unit;
`ifdef BRANCH_STATS_EN
  localparam int SW = 4;
`else
  localparam int SW = 32;
`endif
  logic        clock = 0, reset = 1;
  logic [31:0] f_pc = 0, e_rs1 = 0, e_rs2 = 0, e_pc = 0, e_target = 0;
  logic        e_valid = 0, e_stall = 0, e_pred_tk = 0;
  logic [2:0]  e_funct3 = 0;
  logic        f_pred_tk, br_tk, redirect_valid;
  logic [31:0] redirect_pc;
  int          errors = 0, checks = 0;
  bit          go = 0;
  always #5 clock = ~clock;
`ifdef BRANCH_STATS_EN
  logic [SW-1:0] stat_b, stat_m;
`endif
  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(64), .STAT_W(SW)) dut (
    .clock_i(clock), .reset_i(reset), .f_pc_i(f_pc), .f_pred_tk_o(f_pred_tk),
    .e_valid_i(e_valid), .e_stall_i(e_stall), .e_funct3_i(e_funct3),
    .e_rs1_i(e_rs1), .e_rs2_i(e_rs2), .e_pc_i(e_pc), .e_target_i(e_target),
    .e_pred_tk_i(e_pred_tk), .br_tk_o(br_tk), .redirect_valid_o(redirect_valid),
    .redirect_pc_o(redirect_pc)
`ifdef BRANCH_STATS_EN
    , .stat_branches_o(stat_b), .stat_mispredicts_o(stat_m)
`endif
  );
  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // behavioural model
  int          mbht [64];
  bit          m_tk, m_rv, m_res, m_t;
  logic [31:0] m_pc;
  longint      m_sb, m_sm;
  longint      smax = (64'd1 << SW) - 1;
  function automatic bit outcome(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 == 3'd0) return a == b;
    if (f3 == 3'd1) return a != b;
    if (f3 == 3'd4) return $signed(a) < $signed(b);
    if (f3 == 3'd5) return $signed(a) >= $signed(b);
    if (f3 == 3'd6) return a < b;
    return a >= b;
  endfunction
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mbht[i] = 1;
      m_tk = 0; m_rv = 0; m_pc = 0; m_sb = 0; m_sm = 0;
    end else begin
      m_res = e_valid && !e_stall && !m_rv && e_funct3 != 3'd2 && e_funct3 != 3'd3;
      m_t = outcome(e_funct3, e_rs1, e_rs2);
      if (m_res) begin
        if (m_t) mbht[e_pc[7:2]] = (mbht[e_pc[7:2]] == 3) ? 3 : mbht[e_pc[7:2]] + 1;
        else     mbht[e_pc[7:2]] = (mbht[e_pc[7:2]] == 0) ? 0 : mbht[e_pc[7:2]] - 1;
        m_tk = m_t;
        m_pc = m_t ? e_target : e_pc + 32'd4;
        m_rv = m_t != e_pred_tk;
        if (m_sb < smax) m_sb++;
        if (m_rv && m_sm < smax) m_sm++;
      end else m_rv = 0;
    end
  end
  always @(negedge clock) if (go) begin
    chk("br_tk", br_tk, m_tk);
    chk("redirect_valid", redirect_valid, m_rv);
    chk("redirect_pc", redirect_pc, m_pc);
    chk("f_pred_tk", f_pred_tk, mbht[f_pc[7:2]] >= 2);
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_b, m_sb);
    chk("stat_mispredicts", stat_m, m_sm);
`endif
  end
  task automatic tick();
    @(negedge clock);
    #1;
  endtask
  task automatic br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input logic [31:0] tgt, input bit p);
    e_valid = 1; e_stall = 0; e_funct3 = f3; e_rs1 = a; e_rs2 = b;
    e_pc = pc; e_target = tgt; e_pred_tk = p;
    tick();
    e_valid = 0;
  endtask
  initial begin
    tick();
    go = 1;
    tick();
    reset = 0;
    f_pc = 32'h100;
    #1 chk("t1_pred_reset", f_pred_tk, 0);
    br(3'd0, 5, 5, 32'h100, 32'h80, 0);
    chk("t1_br_tk", br_tk, 1);
    chk("t1_rv", redirect_valid, 1);
    chk("t1_rpc", redirect_pc, 32'h80);
    br(3'd0, 5, 5, 32'h100, 32'h90, 0);
    chk("t4_squash_rv", redirect_valid, 0);
    chk("t4_squash_rpc", redirect_pc, 32'h80);
    chk("t4_bht_pred", f_pred_tk, 1);
    br(3'd1, 3, 3, 32'h100, 32'h84, 1);
    chk("t4_bne_rpc", redirect_pc, 32'h104);
    chk("t4_bht_after_nt", f_pred_tk, 0);
    tick();
    br(3'd4, 32'hFFFFFFFF, 1, 32'h200, 32'h300, 1);
    chk("t2_blt_tk", br_tk, 1);
    chk("t2_blt_rpc", redirect_pc, 32'h300);
    br(3'd6, 32'hFFFFFFFF, 1, 32'h200, 32'h300, 0);
    chk("t2_bltu_tk", br_tk, 0);
    chk("t2_bltu_rpc", redirect_pc, 32'h204);
    br(3'd5, 32'hFFFFFFFF, 1, 32'h208, 32'h400, 1);
    chk("t2_bge_rv", redirect_valid, 1);
    chk("t2_bge_rpc", redirect_pc, 32'h20c);
    tick();
    br(3'd7, 32'hFFFFFFFF, 1, 32'h20c, 32'h500, 1);
    chk("t2_bgeu_rpc", redirect_pc, 32'h500);
    f_pc = 32'h40;
    repeat (3) br(3'd0, 1, 1, 32'h40, 32'h60, 1);
    chk("t3_sat_hi_pred", f_pred_tk, 1);
    repeat (2) br(3'd0, 1, 2, 32'h40, 32'h60, 0);
    chk("t3_two_nt_pred", f_pred_tk, 0);
    repeat (2) br(3'd0, 1, 2, 32'h40, 32'h60, 0);
    br(3'd0, 1, 1, 32'h40, 32'h60, 1);
    chk("t3_from_00_pred", f_pred_tk, 0);
    br(3'd0, 1, 1, 32'h40, 32'h60, 1);
    chk("t3_back_to_10_pred", f_pred_tk, 1);
    e_valid = 1; e_stall = 1; e_funct3 = 3'd0; e_rs1 = 1; e_rs2 = 1;
    e_pc = 32'h80; e_target = 32'h88; e_pred_tk = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stall_rv", redirect_valid, 0);
    end
    e_stall = 0;
    tick();
    e_valid = 0;
    chk("t5_release_rv", redirect_valid, 1);
    chk("t5_release_rpc", redirect_pc, 32'h88);
    tick();
    chk("t5_pulse_end", redirect_valid, 0);
    f_pc = 32'h80;
    #1 chk("t5_one_update", f_pred_tk, 1);
    br(3'd2, 1, 1, 32'h80, 32'h99, 0);
    chk("t5_illegal_rv", redirect_valid, 0);
    chk("t5_illegal_rpc", redirect_pc, 32'h88);
    br(3'd3, 1, 2, 32'h80, 32'h99, 1);
    chk("t5_illegal3_br_tk", br_tk, 1);
    br(3'd0, 1, 2, 32'hFFFFFFFC, 32'h10, 1);
    chk("t6_wrap_rv", redirect_valid, 1);
    chk("t6_wrap_rpc", redirect_pc, 0);
    tick();
    reset = 1;
    br(3'd0, 5, 5, 32'h300, 32'h44, 0);
    reset = 0;
    chk("rst_wins_br_tk", br_tk, 0);
    chk("rst_wins_rv", redirect_valid, 0);
    chk("rst_wins_rpc", redirect_pc, 0);
    f_pc = 32'h40;
    #1 chk("rst_bht_pred", f_pred_tk, 0);
    br(3'd0, 5, 5, 32'h100, 32'h80, 0);
    chk("pend_rv", redirect_valid, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("pend_dropped", redirect_valid, 0);
`ifdef BRANCH_STATS_EN
    repeat (20) begin
      br(3'd0, 5, 5, 32'h100, 32'h80, 0);
      tick();
    end
    chk("t6_stat_b_sat", stat_b, 4'hF);
    chk("t6_stat_m_sat", stat_m, 4'hF);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_stat_b_rst", stat_b, 0);
    chk("t6_stat_m_rst", stat_m, 0);
`endif
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
